// File: rtl/par_data_receiver_pkg.sv
// Shared types and constants for the per-lane TSPIN data receivers.
package par_data_receiver_pkg;

  localparam int ENC_DATA_BITS = 216;
  localparam int SYNC_BITS = 8;
  localparam logic [SYNC_BITS-1:0] SYNCWORD = 8'hff;

  typedef enum logic {RX_HUNT, RX_RECV} rx_state_t;

  typedef struct packed {
    logic [ENC_DATA_BITS-1:0] data;
  } par_data_pkt_t;

endpackage

// File: rtl/par_data_receiver_sync_detect.sv
// Syncword hunter: shift register that flags when the incoming bit completes SYNC_VAL.
import par_data_receiver_pkg::*;

module sync_detect #(
  parameter int SYNC_W = SYNC_BITS,
  parameter logic [SYNC_W-1:0] SYNC_VAL = SYNCWORD
) (
  input  logic clk,
  input  logic rst_l,
  input  logic en,
  input  logic din,
  input  logic clr,
  output logic hit
);

  logic [SYNC_W-1:0] sync_sr;
  logic [SYNC_W-1:0] sync_nxt;

  assign sync_nxt = {sync_sr[SYNC_W-2:0], din};
  assign hit = en && (sync_nxt == SYNC_VAL);

  // A detected syncword clears the window so its bits never seed the next hunt.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_sr <= '0;
    end else if (clr || hit) begin
      sync_sr <= '0;
    end else if (en) begin
      sync_sr <= sync_nxt;
    end
  end

endmodule

// File: rtl/par_data_receiver.sv
// Per-lane serial receiver: hunts for the syncword, deserializes one encoded word MSB-first,
// and hands it to the decoder over a valid/ack handshake.
import par_data_receiver_pkg::*;

module par_data_receiver #(
  parameter int DATA_W = ENC_DATA_BITS,
  parameter int SYNC_W = SYNC_BITS,
  parameter logic [SYNC_W-1:0] SYNC_VAL = SYNCWORD
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              en,
  input  logic              serial_in,
  input  logic              abort,
  input  logic              pkt_ack,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_valid,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_p0;
  logic              vld_p0;
  logic              hunt_en;
  logic              sync_hit;
  logic              recv_en;
  logic              last_bit;

  assign hunt_en  = en && (state == RX_HUNT);
  assign recv_en  = en && (state == RX_RECV);
  assign last_bit = recv_en && (bit_cnt == CNT_W'(DATA_W - 1));

  sync_detect #(
    .SYNC_W   (SYNC_W),
    .SYNC_VAL (SYNC_VAL)
  ) u_sync_detect (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (hunt_en),
    .din   (serial_in),
    .clr   (abort),
    .hit   (sync_hit)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= RX_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = RX_HUNT;
    end else begin
      case (state)
        RX_HUNT: if (sync_hit) state_nxt = RX_RECV;
        RX_RECV: if (last_bit) state_nxt = RX_HUNT;
        default: state_nxt = RX_HUNT;
      endcase
    end
  end

  always_comb begin
    busy = (state == RX_RECV);
  end

  // Stage p0: deserialize; vld_p0 marks a word completed on the previous edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      bit_cnt <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= last_bit && !abort;
      if (abort || sync_hit || last_bit) begin
        bit_cnt <= '0;
      end else if (recv_en) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (recv_en && !abort) begin
      shift_p0 <= {shift_p0[DATA_W-2:0], serial_in};
    end
  end

  // Stage p1: holding register and handshake; a new word always wins over a pending ack.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (vld_p0) begin
      pkt_data  <= shift_p0;
      pkt_valid <= 1'b1;
      overrun   <= pkt_valid && !pkt_ack;
    end else begin
      overrun <= 1'b0;
      if (pkt_ack) begin
        pkt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_par_data_receiver.sv
// Directed bench for par_data_receiver with a bit-stream reference model checked every cycle.
module tb_par_data_receiver;
  import par_data_receiver_pkg::*;

  localparam int W = ENC_DATA_BITS;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic         en = 1'b0;
  logic         serial_in = 1'b0;
  logic         abort = 1'b0;
  logic         pkt_ack = 1'b0;
  logic [W-1:0] pkt_data;
  logic         pkt_valid;
  logic         overrun;
  logic         busy;

  always #5 clk = ~clk;

  par_data_receiver dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .en        (en),
    .serial_in (serial_in),
    .abort     (abort),
    .pkt_ack   (pkt_ack),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a window over the sampled bit stream and an indexed payload buffer.
  bit           m_hunt = 1'b1;
  logic [7:0]   m_win = 8'h00;
  int           m_cnt = 0;
  logic [W-1:0] m_word = '0;
  bit           m_pend = 1'b0;
  logic [W-1:0] m_pend_word = '0;
  logic [W-1:0] e_data = '0;
  bit           e_valid = 1'b0;
  bit           e_ovr = 1'b0;
  bit           e_busy = 1'b0;

  always @(posedge clk) begin
    if (!rst_l) begin
      m_hunt = 1'b1; m_win = 8'h00; m_cnt = 0; m_pend = 1'b0;
      e_data = '0; e_valid = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    end else begin
      if (m_pend) begin
        e_ovr   = e_valid && !pkt_ack;
        e_data  = m_pend_word;
        e_valid = 1'b1;
      end else begin
        e_ovr = 1'b0;
        if (pkt_ack) e_valid = 1'b0;
      end
      m_pend = 1'b0;
      if (abort) begin
        m_hunt = 1'b1; m_win = 8'h00; m_cnt = 0;
      end else if (en) begin
        if (m_hunt) begin
          m_win = {m_win[6:0], serial_in};
          if (m_win == 8'hff) begin
            m_hunt = 1'b0; m_win = 8'h00; m_cnt = 0;
          end
        end else begin
          m_word[W-1-m_cnt] = serial_in;
          m_cnt++;
          if (m_cnt == W) begin
            m_pend = 1'b1; m_pend_word = m_word; m_hunt = 1'b1; m_cnt = 0;
          end
        end
      end
      e_busy = !m_hunt;
    end
  end

  int cyc = 0;
  int busy_cnt = 0;
  int valid_rises = 0;
  int ovr_cnt = 0;
  int last_busy_rise = 0;
  int last_valid_rise = 0;
  bit prev_busy = 1'b0;
  bit prev_valid = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc++;
    n_tests++;
    if (pkt_data !== e_data || pkt_valid !== e_valid || overrun !== e_ovr || busy !== e_busy) begin
      n_fail++;
      $display("FAIL cycle_check cyc=%0d got data=%h valid=%b ovr=%b busy=%b want data=%h valid=%b ovr=%b busy=%b",
               cyc, pkt_data, pkt_valid, overrun, busy, e_data, e_valid, e_ovr, e_busy);
    end
    if (busy) busy_cnt++;
    if (overrun) ovr_cnt++;
    if (busy && !prev_busy) last_busy_rise = cyc;
    if (pkt_valid && !prev_valid) begin
      valid_rises++;
      last_valid_rise = cyc;
    end
    prev_busy  = busy;
    prev_valid = pkt_valid;
  end

  task automatic check_lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    serial_in = b;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_pkt(input logic [7:0] pat, input int gap);
    send_byte(8'hff, gap);
    for (int i = 0; i < W / 8; i++) send_byte(pat, gap);
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    serial_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_word();
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
  endtask

  int b0, r0, o0;
  logic [W-1:0] partial;

  initial begin
    repeat (3) @(negedge clk);
    check_lit("reset_data", pkt_data, '0);
    check_lit("reset_valid", W'(pkt_valid), '0);
    check_lit("reset_busy", W'(busy), '0);
    check_lit("reset_overrun", W'(overrun), '0);
    rst_l = 1'b1;
    @(negedge clk);

    // Continuous strobe
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1);
    b0 = busy_cnt; r0 = valid_rises;
    send_pkt(8'hA5, 1);
    idle(2);
    check_lit("t1_data", pkt_data, {27{8'hA5}});
    check_lit("t1_valid", W'(pkt_valid), W'(1));
    check_lit("t1_busy_cycles", W'(busy_cnt - b0), W'(216));
    check_lit("t1_latency", W'(last_valid_rise - last_busy_rise), W'(217));
    check_lit("t1_rises", W'(valid_rises - r0), W'(1));
    ack_word();

    // Strobe every third cycle
    b0 = busy_cnt;
    send_pkt(8'hA5, 3);
    idle(2);
    check_lit("t2_data", pkt_data, {27{8'hA5}});
    check_lit("t2_busy_cycles", W'(busy_cnt - b0), W'(648));
    check_lit("t2_latency", W'(last_valid_rise - last_busy_rise), W'(649));
    ack_word();

    // All-ones payload followed by a near-sync tail
    b0 = busy_cnt; r0 = valid_rises;
    send_byte(8'hff, 1);
    for (int i = 0; i < W; i++) send_bit(1'b1, 1);
    send_byte(8'hFE, 1);
    idle(3);
    check_lit("t3_data", pkt_data, {W{1'b1}});
    check_lit("t3_rises", W'(valid_rises - r0), W'(1));
    check_lit("t3_busy_after", W'(busy), '0);
    check_lit("t3_busy_cycles", W'(busy_cnt - b0), W'(216));
    ack_word();

    // Back-to-back without ack, then completion with ack
    o0 = ovr_cnt;
    send_pkt(8'h11, 1);
    send_pkt(8'h22, 1);
    idle(2);
    check_lit("t4_overrun", W'(ovr_cnt - o0), W'(1));
    check_lit("t4_data", pkt_data, {27{8'h22}});
    check_lit("t4_valid", W'(pkt_valid), W'(1));
    o0 = ovr_cnt;
    send_pkt(8'h11, 1);
    ack_word();
    idle(2);
    check_lit("t4_ack_overrun", W'(ovr_cnt - o0), '0);
    check_lit("t4_ack_data", pkt_data, {27{8'h11}});
    check_lit("t4_ack_valid", W'(pkt_valid), W'(1));

    // Abort part way through a payload
    partial = {27{8'hA5}};
    send_byte(8'hff, 1);
    for (int i = 0; i < 100; i++) send_bit(partial[W-1-i], 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle(2);
    check_lit("t5_busy", W'(busy), '0);
    check_lit("t5_valid_kept", W'(pkt_valid), W'(1));
    check_lit("t5_data_kept", pkt_data, {27{8'h11}});
    ack_word();
    r0 = valid_rises;
    send_pkt(8'h3C, 1);
    idle(2);
    check_lit("t5_data", pkt_data, {27{8'h3C}});
    check_lit("t5_rises", W'(valid_rises - r0), W'(1));

    // Reset in the middle of a payload
    send_byte(8'hff, 1);
    for (int i = 0; i < 50; i++) send_bit(partial[W-1-i], 1);
    rst_l = 1'b0;
    #2;
    check_lit("t6_rst_data", pkt_data, '0);
    check_lit("t6_rst_valid", W'(pkt_valid), '0);
    check_lit("t6_rst_busy", W'(busy), '0);
    check_lit("t6_rst_overrun", W'(overrun), '0);
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    o0 = ovr_cnt; r0 = valid_rises;
    send_pkt(8'hA5, 1);
    idle(2);
    check_lit("t6_data", pkt_data, {27{8'hA5}});
    check_lit("t6_overrun", W'(ovr_cnt - o0), '0);
    check_lit("t6_rises", W'(valid_rises - r0), W'(1));

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
